hazard_ctrl: RTL and testbench

//  Hazard/scheduling controller for the D->E pipeline register and the E-stage operand path.

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the D->E boundary with a Tuse/Tnew scoreboard and MD busy sequencer.
// Optional macro HAZARD_STALL_CNT_EN adds a 32-bit stall-cycle counter output (perf_stall_cnt).
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  read1addr_D,
    input  logic [4:0]  read2addr_D,
    input  logic [1:0]  tuse1_D,
    input  logic [1:0]  tuse2_D,
    input  logic        rfwe_D,
    input  logic [4:0]  writeaddr_D,
    input  logic [1:0]  tnew_D,
    input  logic        md_start_D,
    input  logic        md_div_D,
    input  logic        md_use_D,
    output logic        stall_D,
    output logic        CLR_E,
    output logic [1:0]  fwd1_D,
    output logic [1:0]  fwd2_D,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    logic             e_we_reg, m_we_reg, w_we_reg;
    logic [4:0]       e_waddr_reg, m_waddr_reg, w_waddr_reg;
    logic [1:0]       e_tnew_reg, m_tnew_reg;
    logic [4:0]       e_r1_reg, e_r2_reg;
    logic             e_md_reg, e_div_reg;
    md_state_t        md_state_reg;
    logic [CNT_W-1:0] md_cnt_reg;

    logic [4:0] src_addr [2];
    logic [1:0] src_tuse [2];
    logic [4:0] e_src    [2];
    logic [1:0] fwd_d    [2];
    logic [1:0] fwd_e    [2];
    logic [1:0] stall_src;
    logic       stall;

    assign src_addr[0] = read1addr_D;
    assign src_addr[1] = read2addr_D;
    assign src_tuse[0] = tuse1_D;
    assign src_tuse[1] = tuse2_D;
    assign e_src[0]    = e_r1_reg;
    assign e_src[1]    = e_r2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic e_hit, m_hit, em_hit, ew_hit;

            assign e_hit  = (src_addr[gi] != 5'd0) && e_we_reg && (e_waddr_reg == src_addr[gi]);
            assign m_hit  = (src_addr[gi] != 5'd0) && m_we_reg && (m_waddr_reg == src_addr[gi]);
            assign em_hit = (e_src[gi] != 5'd0) && m_we_reg && (m_waddr_reg == e_src[gi]);
            assign ew_hit = (e_src[gi] != 5'd0) && w_we_reg && (w_waddr_reg == e_src[gi]);

            // A producer stalls the reader only if its result arrives later than the reader needs it.
            assign stall_src[gi] = (src_tuse[gi] != 2'd3) &&
                                   ((e_hit && (e_tnew_reg > src_tuse[gi])) ||
                                    (m_hit && (m_tnew_reg > src_tuse[gi])));

            assign fwd_d[gi] = (e_hit && (e_tnew_reg == 2'd0)) ? 2'd1 :
                               (m_hit && (m_tnew_reg == 2'd0)) ? 2'd2 : 2'd0;

            assign fwd_e[gi] = (em_hit && (m_tnew_reg == 2'd0)) ? 2'd1 :
                               ew_hit ? 2'd2 : 2'd0;
        end
    endgenerate

    // The MD op sitting in E counts as busy so the very next HI/LO user is held.
    assign md_busy = (md_state_reg == MD_BUSY) | e_md_reg;
    assign stall   = (|stall_src) | (md_use_D & md_busy);
    assign stall_D = stall;
    assign CLR_E   = stall;
    assign fwd1_D  = fwd_d[0];
    assign fwd2_D  = fwd_d[1];
    assign fwdA_E  = fwd_e[0];
    assign fwdB_E  = fwd_e[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_we_reg    <= 1'b0;
            e_waddr_reg <= 5'd0;
            e_tnew_reg  <= 2'd0;
            e_r1_reg    <= 5'd0;
            e_r2_reg    <= 5'd0;
            e_md_reg    <= 1'b0;
            e_div_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_waddr_reg <= 5'd0;
            m_tnew_reg  <= 2'd0;
            w_we_reg    <= 1'b0;
            w_waddr_reg <= 5'd0;
        end else begin
            if (stall) begin
                e_we_reg    <= 1'b0;
                e_waddr_reg <= 5'd0;
                e_tnew_reg  <= 2'd0;
                e_r1_reg    <= 5'd0;
                e_r2_reg    <= 5'd0;
                e_md_reg    <= 1'b0;
                e_div_reg   <= 1'b0;
            end else begin
                e_we_reg    <= rfwe_D;
                e_waddr_reg <= writeaddr_D;
                e_tnew_reg  <= tnew_D;
                e_r1_reg    <= read1addr_D;
                e_r2_reg    <= read2addr_D;
                e_md_reg    <= md_start_D;
                e_div_reg   <= md_div_D;
            end
            m_we_reg    <= e_we_reg;
            m_waddr_reg <= e_waddr_reg;
            m_tnew_reg  <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
            w_we_reg    <= m_we_reg;
            w_waddr_reg <= m_waddr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_reg <= MD_IDLE;
            md_cnt_reg   <= '0;
        end else begin
            case (md_state_reg)
                MD_IDLE: begin
                    if (e_md_reg) begin
                        md_state_reg <= MD_BUSY;
                        md_cnt_reg   <= e_div_reg ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_reg == CNT_W'(1)) begin
                        md_state_reg <= MD_IDLE;
                        md_cnt_reg   <= '0;
                    end else begin
                        md_cnt_reg   <= md_cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    md_state_reg <= MD_IDLE;
                    md_cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall_cnt <= 32'd0;
        else if (stall)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: pipeline hazard table plus MD busy and reset sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read1addr_D, read2addr_D, writeaddr_D;
    logic [1:0]  tuse1_D, tuse2_D, tnew_D;
    logic        rfwe_D, md_start_D, md_div_D, md_use_D;
    logic        stall_D, CLR_E, md_busy;
    logic [1:0]  fwd1_D, fwd2_D, fwdA_E, fwdB_E;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .read1addr_D(read1addr_D), .read2addr_D(read2addr_D),
        .tuse1_D(tuse1_D), .tuse2_D(tuse2_D),
        .rfwe_D(rfwe_D), .writeaddr_D(writeaddr_D), .tnew_D(tnew_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .stall_D(stall_D), .CLR_E(CLR_E),
        .fwd1_D(fwd1_D), .fwd2_D(fwd2_D), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r1, r2, wa;
        logic [1:0]  tu1, tu2, tn;
        logic        we, mds, mdd, mdu;
        logic [10:0] exp;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [10:0] outs;
    assign outs = {stall_D, CLR_E, fwd1_D, fwd2_D, fwdA_E, fwdB_E, md_busy};

    function automatic vec_t mk(int r1, int tu1, int r2, int tu2, int we, int wa, int tn,
                                int mds, int mdd, int mdu,
                                int st, int f1, int f2, int fa, int fb, int bz);
        vec_t v;
        v.r1  = 5'(r1);  v.tu1 = 2'(tu1);
        v.r2  = 5'(r2);  v.tu2 = 2'(tu2);
        v.we  = 1'(we);  v.wa  = 5'(wa);  v.tn = 2'(tn);
        v.mds = 1'(mds); v.mdd = 1'(mdd); v.mdu = 1'(mdu);
        v.exp = {1'(st), 1'(st), 2'(f1), 2'(f2), 2'(fa), 2'(fb), 1'(bz)};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        read1addr_D = v.r1; tuse1_D = v.tu1;
        read2addr_D = v.r2; tuse2_D = v.tu2;
        rfwe_D = v.we; writeaddr_D = v.wa; tnew_D = v.tn;
        md_start_D = v.mds; md_div_D = v.mdd; md_use_D = v.mdu;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Apply one D-stage instruction for one cycle, compare mid-cycle, then advance past the edge.
    task automatic step(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        check(name, {21'd0, outs}, {21'd0, v.exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t nop_v, div_v, mfhi_v;
        int   n_st;
        bit   done;
        int   exp_perf;

        // r1 tu1 r2 tu2 we wa tn mds mdd mdu | st f1 f2 fA fB busy
        tbl[0]  = mk(29,1, 0,3, 1, 1,2, 0,0,0,  0,0,0,0,0,0); // lw $1
        tbl[1]  = mk( 1,1, 2,1, 1, 3,1, 0,0,0,  1,0,0,0,0,0); // addu $3,$1: load-use stall
        tbl[2]  = mk( 1,1, 2,1, 1, 3,1, 0,0,0,  0,0,0,0,0,0);
        tbl[3]  = mk( 0,3, 0,3, 0, 0,0, 0,0,0,  0,0,0,2,0,0); // addu in E takes $1 from W
        tbl[4]  = mk( 3,1, 0,3, 1, 5,1, 0,0,0,  0,2,0,0,0,0); // reads $3 from M
        tbl[5]  = mk( 5,0, 0,0, 0, 0,0, 0,0,0,  1,0,0,2,0,0); // beq $5 right behind addu $5
        tbl[6]  = mk( 5,0, 0,0, 0, 0,0, 0,0,0,  0,2,0,0,0,0);
        tbl[7]  = mk( 0,3, 0,3, 1,31,0, 0,0,0,  0,0,0,2,0,0); // jal
        tbl[8]  = mk(31,0, 0,3, 0, 0,0, 0,0,0,  0,1,0,0,0,0); // jr $31: pc8 from E
        tbl[9]  = mk( 0,3, 0,3, 1, 0,1, 0,0,0,  0,0,0,1,0,0); // writer of $0; jr in E takes M
        tbl[10] = mk( 0,0, 0,0, 0, 0,0, 0,0,0,  0,0,0,0,0,0); // $0 reader: no match
        tbl[11] = mk( 0,1, 0,3, 1, 9,2, 0,0,0,  0,0,0,0,0,0); // lw $9
        tbl[12] = mk( 0,0, 9,0, 0, 0,0, 0,0,0,  1,0,0,0,0,0); // beq on rt $9: two stalls
        tbl[13] = mk( 0,0, 9,0, 0, 0,0, 0,0,0,  1,0,0,0,0,0);
        tbl[14] = mk( 0,0, 9,0, 0, 0,0, 0,0,0,  0,0,0,0,0,0);
        tbl[15] = mk( 0,3, 0,3, 1,10,1, 0,0,0,  0,0,0,0,0,0); // addu $10
        tbl[16] = mk( 0,3,10,1, 1,11,1, 0,0,0,  0,0,0,0,0,0); // rt $10 at tuse 1: no stall
        tbl[17] = mk( 0,3, 0,3, 0, 0,0, 0,0,0,  0,0,0,0,1,0); // E operand B from M
        tbl[18] = mk( 0,1, 0,1, 0, 0,0, 1,0,1,  0,0,0,0,0,0); // mult
        for (int i = 19; i < 25; i++)
            tbl[i] = mk(0,3, 0,3, 1,12,1, 0,0,1,  1,0,0,0,0,1); // mflo held 1+MULT_CYC cycles
        tbl[25] = mk( 0,3, 0,3, 1,12,1, 0,0,1,  0,0,0,0,0,0);
        tbl[26] = mk( 0,3, 0,3, 0, 0,0, 0,0,0,  0,0,0,0,0,0);

        nop_v  = mk(0,3, 0,3, 0, 0,0, 0,0,0,  0,0,0,0,0,0);
        div_v  = mk(0,1, 0,1, 0, 0,0, 1,1,1,  0,0,0,0,0,0);
        mfhi_v = mk(0,3, 0,3, 1,13,1, 0,0,1,  0,0,0,0,0,0);

        // Reset held: hazard-looking inputs must not produce any output.
        rst_n = 1'b0;
        drive(mk(1,0, 2,0, 1,1,2, 1,1,1, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {21'd0, outs}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("reset_perf", perf_stall_cnt, 32'd0);
`endif
        drive(nop_v);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        exp_perf = 0;
        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].exp[10]) exp_perf++;
        end

        // div followed by mfhi: held for 1+DIV_CYC cycles.
        step(div_v, "div_issue");
        drive(mfhi_v);
        n_st = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall_D) n_st++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        check("div_release_seen", {31'd0, done}, 32'd1);
        check("div_stall_cycles", n_st, 32'd11);
        exp_perf += 11;
`ifdef HAZARD_STALL_CNT_EN
        check("perf_count", perf_stall_cnt, exp_perf);
`endif
        @(posedge clk);
        #1;
        step(nop_v, "after_div");

        // div again, then reset asynchronously at the third busy cycle.
        step(div_v, "div2_issue");
        drive(mfhi_v);
        @(negedge clk);
        check("div2_busy1", {21'd0, outs}, 32'h601);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("div2_busy2", {21'd0, outs}, 32'h601);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("div2_busy3", {21'd0, outs}, 32'h601);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {21'd0, outs}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("async_reset_perf", perf_stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        check("reset_held_outputs", {21'd0, outs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mfhi_after_reset", {21'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        step(nop_v, "idle_after_reset");
        step(nop_v, "idle_after_reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
